aq_djpeg_idctb_fetch: RTL and testbench



---
 rtl/aq_djpeg_idctb_fetch.sv | 129 ++++++++++++
 tb/tb_aq_djpeg_idctb_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/aq_djpeg_idctb_fetch.sv
// Fetches butterfly pairs from the IDCT transpose buffer: issues reads under
// a 2-deep credit, undoes the buffer's bank lane swap, forms A+B / A-B.
module aq_djpeg_idctb_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        DataInit,
  input  logic        IdctbEnable,
  output logic        IdctbRead,
  output logic [4:0]  IdctbAddress,
  input  logic [15:0] IdctbA,
  input  logic [15:0] IdctbB,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [2:0]  OutPage,
  output logic [1:0]  OutCount,
  output logic [16:0] OutSum,
  output logic [16:0] OutDiff,
  output logic        OutLast,
  output logic        Busy
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  typedef struct packed {
    logic [4:0]  addr;
    logic [16:0] sum;
    logic [16:0] diff;
  } pair_t;

  state_e      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic        rd_q;
  logic [4:0]  rd_addr_q;
  pair_t       fifo_q [2];
  pair_t       head, cap;
  logic        wptr_q, rptr_q;
  logic [1:0]  cnt_q, lvl;
  logic        pop, swap;
  logic [15:0] lane_a, lane_b;
  logic [16:0] a_x, b_x;

  assign OutValid     = (cnt_q != 2'd0);
  assign pop          = OutValid & OutReady;
  // Occupancy once this edge's capture and pop land; a new read may only
  // be issued if it still has a guaranteed slot.
  assign lvl          = cnt_q + {1'b0, rd_q} - {1'b0, pop};
  assign IdctbAddress = addr_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    IdctbRead = 1'b0;
    case (state_q)
      IDLE: if (IdctbEnable) begin
        state_d = RUN;
        addr_d  = 5'd0;
      end
      RUN: if (lvl < 2'd2) begin
        IdctbRead = 1'b1;
        addr_d    = addr_q + 5'd1;
        if (addr_q == 5'd31) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (DataInit) begin
      state_d   = IDLE;
      addr_d    = 5'd0;
      IdctbRead = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // The buffer swaps lanes by the address presented now, not the one the
  // data belongs to; undo it when the bank bit changed since issue.
  assign swap   = IdctbAddress[4] ^ rd_addr_q[4];
  assign lane_a = swap ? IdctbB : IdctbA;
  assign lane_b = swap ? IdctbA : IdctbB;
  assign a_x    = {lane_a[15], lane_a};
  assign b_x    = {lane_b[15], lane_b};

  always_comb begin
    cap.addr = rd_addr_q;
    cap.sum  = a_x + b_x;
    cap.diff = a_x - b_x;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q      <= 1'b0;
      rd_addr_q <= 5'd0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      cnt_q     <= 2'd0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (DataInit) begin
      rd_q   <= 1'b0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      rd_q <= IdctbRead;
      if (IdctbRead) rd_addr_q <= addr_q;
      if (rd_q) begin
        fifo_q[wptr_q] <= cap;
        wptr_q         <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= lvl;
    end
  end

  assign head     = fifo_q[rptr_q];
  assign OutPage  = head.addr[4:2];
  assign OutCount = head.addr[1:0];
  assign OutSum   = head.sum;
  assign OutDiff  = head.diff;
  assign OutLast  = OutValid & (head.addr == 5'd31);
  assign Busy     = (state_q == RUN) | rd_q | OutValid;

endmodule

// File: tb/tb_aq_djpeg_idctb_fetch.sv
// Bench for aq_djpeg_idctb_fetch: transpose-buffer model with physical lane
// layout, bank-ordered scoreboard of expected pairs, directed scenarios.
module tb_aq_djpeg_idctb_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        DataInit = 1'b0, IdctbEnable = 1'b0, OutReady = 1'b0;
  logic        IdctbRead, OutValid, OutLast, Busy;
  logic [4:0]  IdctbAddress;
  logic [15:0] IdctbA, IdctbB;
  logic [2:0]  OutPage;
  logic [1:0]  OutCount;
  logic [16:0] OutSum, OutDiff;

  aq_djpeg_idctb_fetch dut (
    .clk(clk), .rst(rst), .DataInit(DataInit), .IdctbEnable(IdctbEnable),
    .IdctbRead(IdctbRead), .IdctbAddress(IdctbAddress),
    .IdctbA(IdctbA), .IdctbB(IdctbB), .OutValid(OutValid), .OutReady(OutReady),
    .OutPage(OutPage), .OutCount(OutCount), .OutSum(OutSum), .OutDiff(OutDiff),
    .OutLast(OutLast), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct {int addr; int sum; int diff;} exp_t;
  exp_t exp_q[$];

  // Physical storage: banks with address bit 4 set keep B in lane 0.
  // The read port presents lane 0 on IdctbA unless the current address has
  // bit 4 set. Two bank slots alternate as banks are consumed.
  logic [15:0] phys0 [2][32];
  logic [15:0] phys1 [2][32];
  logic [4:0]  ra;
  logic        rb, bk;
  int          ld = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra <= 5'd0; rb <= 1'b0; bk <= 1'b0;
    end else if (DataInit) begin
      bk <= 1'b0;
    end else if (IdctbRead) begin
      ra <= IdctbAddress;
      rb <= bk;
      if (IdctbAddress == 5'd31) bk <= ~bk;
    end
  end

  assign IdctbA = IdctbAddress[4] ? phys1[rb][ra] : phys0[rb][ra];
  assign IdctbB = IdctbAddress[4] ? phys0[rb][ra] : phys1[rb][ra];

  int t, read_cycles, streak, max_streak, first_rd, last_rd, lasts, first_valid;

  task automatic reset_stats();
    t = 0; read_cycles = 0; streak = 0; max_streak = 0;
    first_rd = -1; last_rd = -1; lasts = 0; first_valid = -1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // mode 0: A=addr, B=-addr; mode 1: random with extreme pairs planted.
  task automatic load_bank(input int mode);
    int s;
    exp_t e;
    s = ld % 2;
    for (int i = 0; i < 32; i++) begin
      logic [15:0] a, b;
      logic [4:0]  ia;
      ia = i[4:0];
      if (mode == 0) begin
        a = 16'(i); b = 16'(-i);
      end else if (i == 5) begin
        a = 16'h7FFF; b = 16'h7FFF;
      end else if (i == 22) begin
        a = 16'h8000; b = 16'h8000;
      end else begin
        a = 16'($urandom); b = 16'($urandom);
      end
      phys0[s][i] = ia[4] ? b : a;
      phys1[s][i] = ia[4] ? a : b;
      e.addr = i;
      e.sum  = int'($signed(a)) + int'($signed(b));
      e.diff = int'($signed(a)) - int'($signed(b));
      exp_q.push_back(e);
    end
    ld++;
  endtask

  // Apply inputs for one cycle, observe just before the coming edge.
  task automatic cyc(input logic rdy, input logic en, input logic init);
    exp_t e;
    logic [39:0] want;
    OutReady = rdy; IdctbEnable = en; DataInit = init;
    #1;
    if (IdctbRead) begin
      read_cycles++; streak++;
      if (streak > max_streak) max_streak = streak;
      if (first_rd < 0) first_rd = t;
      last_rd = t;
    end else streak = 0;
    if (OutValid && first_valid < 0) first_valid = t;
    if (OutValid && OutReady) begin
      if (OutLast) lasts++;
      chk("pair_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        want = {e.addr[4:0], e.sum[16:0], e.diff[16:0], (e.addr == 31)};
        chk("pair", {OutPage, OutCount, OutSum, OutDiff, OutLast}, want);
      end
    end
    t++;
    @(negedge clk);
  endtask

  task automatic drain(input int en_until, input bit rnd, input int stall_at, input int maxc);
    int stall_n = 0;
    bit done = 0, stalling;
    logic rdy;
    logic [39:0] held;
    for (int i = 0; i < maxc && !done; i++) begin
      stalling = (stall_at > 0) && (read_cycles >= stall_at) && (stall_n < 10);
      rdy = stalling ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (stalling) begin
        if (stall_n == 0) begin
          chk("stall_valid", 64'(OutValid), 64'd1);
          held = {OutPage, OutCount, OutSum, OutDiff, OutLast};
        end else begin
          chk("stall_hold", {OutValid, OutPage, OutCount, OutSum, OutDiff, OutLast}, {1'b1, held});
          chk("stall_noread", 64'(IdctbRead), 64'd0);
        end
      end
      cyc(rdy, read_cycles < en_until, 1'b0);
      if (stalling) stall_n++;
      done = (exp_q.size() == 0) && !Busy;
    end
    chk("drain_done", {exp_q.size() == 0, Busy}, 64'b10);
  endtask

  task automatic reset_outs(input string tag);
    chk({tag, "_read"},  64'(IdctbRead), 64'd0);
    chk({tag, "_valid"}, 64'(OutValid), 64'd0);
    chk({tag, "_last"},  64'(OutLast), 64'd0);
    chk({tag, "_busy"},  64'(Busy), 64'd0);
    chk({tag, "_sum"},   64'(OutSum), 64'd0);
    chk({tag, "_diff"},  64'(OutDiff), 64'd0);
    chk({tag, "_pc"},    64'({OutPage, OutCount}), 64'd0);
    chk({tag, "_addr"},  64'(IdctbAddress), 64'd0);
  endtask

  initial begin
    reset_stats();
    #1 rst = 1'b0;
    #2 reset_outs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Counting bank: latency, 32 back-to-back reads, single OutLast.
    load_bank(0); reset_stats();
    drain(1, 1'b0, 0, 100);
    chk("first_valid_lat", 64'(first_valid), 64'd3);
    chk("read_streak", 64'(max_streak), 64'd32);
    chk("read_count", 64'(read_cycles), 64'd32);
    chk("last_pulses", 64'(lasts), 64'd1);

    // Random data including saturating corners, random backpressure.
    load_bank(1); reset_stats();
    drain(1, 1'b1, 0, 400);
    chk("rnd_read_count", 64'(read_cycles), 64'd32);

    // Ten-cycle stall mid-bank.
    load_bank(1); reset_stats();
    drain(1, 1'b0, 10, 200);

    // Two banks back to back.
    load_bank(0); load_bank(1); reset_stats();
    drain(33, 1'b0, 0, 300);
    chk("two_bank_reads", 64'(read_cycles), 64'd64);
    chk("two_bank_span", 64'(last_rd - first_rd), 64'd64);
    chk("two_bank_lasts", 64'(lasts), 64'd2);

    // Flush at address 20 with the output buffer full.
    load_bank(1); reset_stats();
    for (int i = 0; i < 100 && IdctbAddress != 5'd20; i++) cyc(1'b1, read_cycles < 1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("pre_init_valid", 64'(OutValid), 64'd1);
    exp_q.delete(); ld = 0;
    cyc(1'b0, 1'b0, 1'b1);
    DataInit = 1'b0;
    #1;
    chk("init_valid", 64'(OutValid), 64'd0);
    chk("init_busy", 64'(Busy), 64'd0);
    chk("init_addr", 64'(IdctbAddress), 64'd0);
    chk("init_read", 64'(IdctbRead), 64'd0);
    @(negedge clk);

    load_bank(0); reset_stats();
    drain(1, 1'b1, 0, 400);

    // Asynchronous reset mid-bank, then no restart until enabled.
    load_bank(1); reset_stats();
    for (int i = 0; i < 100 && read_cycles < 12; i++) cyc(1'b1, read_cycles < 1, 1'b0);
    #2 rst = 1'b0;
    #1 reset_outs("async");
    exp_q.delete(); ld = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("no_restart", {Busy, IdctbAddress}, 64'd0);
    load_bank(0); reset_stats();
    drain(1, 1'b0, 0, 100);
    chk("post_reset_reads", 64'(read_cycles), 64'd32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
